// File: rtl/mdu_divider_if.sv
// Request/response bundle between the execute stage and the RV32M divider.
interface mdu_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic         is_signed;
    logic         want_rem;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         kill;
    logic         busy;
    logic         stall;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, is_signed, want_rem, dividend, divisor, kill,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, is_signed, want_rem, dividend, divisor, kill,
        output busy, stall, done, result
    );
endinterface

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; N iterations plus one sign-fix cycle.
// Divide-by-zero and signed overflow take a one-cycle fast path to DONE.
module mdu_divider #(
    parameter int N = 32
) (
    input logic          clk,
    input logic          rst,
    mdu_divider_if.slave bus
);
    localparam int           CW      = $clog2(N);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t        state;
    logic [N-1:0]  rem, quo, dvs, result_q;
    logic [CW-1:0] cnt;
    logic          neg_q, neg_r, want_rem_q, busy_q, done_q;

    logic          a_neg, b_neg, ovf;
    logic [N-1:0]  mag_a, mag_b;
    logic [N:0]    shifted, trial;
    logic [N-1:0]  rem_step, quo_step, quo_fix, rem_fix;

    assign a_neg = bus.is_signed & bus.dividend[N-1];
    assign b_neg = bus.is_signed & bus.divisor[N-1];
    assign mag_a = a_neg ? -bus.dividend : bus.dividend;
    assign mag_b = b_neg ? -bus.divisor : bus.divisor;
    assign ovf   = bus.is_signed & (bus.dividend == INT_MIN) & (bus.divisor == '1);

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted  = {rem, quo[N-1]};
        trial    = shifted - {1'b0, dvs};
        rem_step = trial[N] ? shifted[N-1:0] : trial[N-1:0];
        quo_step = {quo[N-2:0], ~trial[N]};
    end

    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;

    // NOTE: sequential state is assigned with <= only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            quo        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            want_rem_q <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        want_rem_q <= bus.want_rem;
                        neg_q      <= a_neg ^ b_neg;
                        neg_r      <= a_neg;
                        quo        <= mag_a;
                        dvs        <= mag_b;
                        rem        <= '0;
                        cnt        <= '0;
                        if (bus.divisor == '0) begin
                            result_q <= bus.want_rem ? bus.dividend : '1;
                            state    <= DONE;
                            done_q   <= 1'b1;
                        end else if (ovf) begin
                            result_q <= bus.want_rem ? '0 : bus.dividend;
                            state    <= DONE;
                            done_q   <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    result_q <= want_rem_q ? rem_fix : quo_fix;
                    state    <= DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational so the downstream register is frozen in the very cycle a start is accepted.
    assign bus.stall  = (bus.start & (state == IDLE) & ~bus.kill) | busy_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
